// File: rtl/text_overlay.sv
// Text-mode overlay: character buffer, clear sequencer and
// 3-stage pixel pipeline feeding an external character ROM.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   pixel_x/pixel_y/video_on  VGA timing inputs
//   wr_en/wr_col/wr_row/wr_char  single-cell buffer write
//   clear_req               start a full-buffer fill with 0x20
//   char_code/rom_row       address into character ROM (registered)
//   row_data                glyph row from ROM, bit 7 = leftmost
//   text_pixel/text_valid   pixel output, 3 cycles after inputs
//   busy                    clear sequence in progress
module text_overlay #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       wr_en,
    input  logic [6:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [7:0] wr_char,
    input  logic       clear_req,
    output logic [7:0] char_code,
    output logic [3:0] rom_row,
    input  logic [7:0] row_data,
    output logic       text_pixel,
    output logic       text_valid,
    output logic       busy
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);
    localparam logic [6:0]    COLS_W = 7'(COLS);
    localparam logic [4:0]    ROWS_W = 5'(ROWS);
    localparam logic [9:0]    X_MAX  = 10'(COLS * 8);
    localparam logic [9:0]    Y_MAX  = 10'(ROWS * 16);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    // ---------------- buffer write port ----------------
    logic          wr_ok;
    logic [AW-1:0] wr_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    assign wr_ok   = wr_en && (wr_col < COLS_W) && (wr_row < ROWS_W);
    assign wr_addr = AW'(wr_row) * COLS_A + AW'(wr_col);

    // Clear owns the port while busy; a host write coinciding
    // with a clear request is dropped. Nothing writes in reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 8'h00;
        if (!reset) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = 8'h20;
            end else if (wr_ok && !clear_req) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = wr_char;
            end
        end
    end

    // Power-up image is all spaces; reset never touches it.
    logic [7:0] mem_q [DEPTH] = '{default: 8'h20};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- stage 1 ----------------
    logic          inr_d;
    logic [AW-1:0] rd_addr_d;
    logic [AW-1:0] s1_addr_q;
    logic [2:0]    s1_px_q;
    logic [3:0]    s1_py_q;
    logic          s1_von_q;
    logic          s1_inr_q;

    assign inr_d = (pixel_x < X_MAX) && (pixel_y < Y_MAX);

    // Out-of-range coordinates read cell 0; result is masked later.
    assign rd_addr_d = inr_d
        ? AW'(pixel_y[8:4]) * COLS_A + AW'(pixel_x[9:3])
        : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr_q <= '0;
            s1_px_q   <= '0;
            s1_py_q   <= '0;
            s1_von_q  <= 1'b0;
            s1_inr_q  <= 1'b0;
        end else begin
            s1_addr_q <= rd_addr_d;
            s1_px_q   <= pixel_x[2:0];
            s1_py_q   <= pixel_y[3:0];
            s1_von_q  <= video_on;
            s1_inr_q  <= inr_d;
        end
    end

    // ---------------- stage 2 ----------------
    // The synchronous read register is char_code itself, so a
    // same-address write in this cycle returns the old value.
    logic [7:0] char_q;
    logic [3:0] row_q;
    logic [2:0] s2_px_q;
    logic       s2_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            char_q   <= 8'h00;
            row_q    <= '0;
            s2_px_q  <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            char_q   <= mem_q[s1_addr_q];
            row_q    <= s1_py_q;
            s2_px_q  <= s1_px_q;
            s2_vld_q <= s1_von_q && s1_inr_q;
        end
    end

    assign char_code = char_q;
    assign rom_row   = row_q;

    // ---------------- stage 3 ----------------
    logic pix_q;
    logic vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            pix_q <= s2_vld_q && !busy && row_data[3'd7 - s2_px_q];
            vld_q <= s2_vld_q;
        end
    end

    assign text_pixel = pix_q;
    assign text_valid = vld_q;

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: reference buffer model,
// behavioural character ROM and queued pixel expectations.
module tb_text_overlay;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on;
    logic       wr_en;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_char;
    logic       clear_req;
    logic [7:0] char_code;
    logic [3:0] rom_row;
    logic [7:0] row_data;
    logic       text_pixel, text_valid, busy;

    always #5 clk = ~clk;

    text_overlay #(.COLS(80), .ROWS(30)) dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
        .wr_char(wr_char), .clear_req(clear_req),
        .char_code(char_code), .rom_row(rom_row), .row_data(row_data),
        .text_pixel(text_pixel), .text_valid(text_valid), .busy(busy)
    );

    function automatic logic [7:0] glyph(input logic [7:0] c,
                                         input logic [3:0] r);
        if (c == 8'h20) return 8'h00;
        if (c == 8'h41) begin
            case (r)
                4'd0:    return 8'h3C;
                4'd6:    return 8'h66;
                default: return 8'h5A ^ {r, r};
            endcase
        end
        return c ^ {r, 4'hA};
    endfunction

    always_comb row_data = glyph(char_code, rom_row);

    typedef struct {
        int         due;
        logic       pix;
        logic       vld;
        logic       chk_ch;
        logic [7:0] ch;
        logic [3:0] row;
    } ent_t;

    ent_t       pq[$];
    ent_t       cq[$];
    logic [7:0] model [2400];
    int         cyc, n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic drain();
        ent_t e;
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            e = cq.pop_front();
            chk("rom_row", 32'(rom_row), 32'(e.row));
            if (e.chk_ch) chk("char_code", 32'(char_code), 32'(e.ch));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk("text_pixel", 32'(text_pixel), 32'(e.pix));
            chk("text_valid", 32'(text_valid), 32'(e.vld));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drain();
    endtask

    task automatic idle(input int n);
        video_on = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic push_pix(input int x, input int y, input bit von,
                            input bit clearing);
        ent_t       e;
        bit         inr;
        logic [7:0] ch;
        logic [7:0] g;
        logic [3:0] r;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        inr = (x < 640) && (y < 480);
        ch  = inr ? model[(y / 16) * 80 + x / 8] : 8'h00;
        r   = 4'(y % 16);
        g   = glyph(ch, r);
        e.due    = cyc + 3;
        e.vld    = von && inr;
        e.pix    = e.vld && !clearing && g[3'(7 - x % 8)];
        e.chk_ch = 1'b0;
        e.ch     = 8'h00;
        e.row    = r;
        pq.push_back(e);
        e.due    = cyc + 2;
        e.chk_ch = inr && !clearing;
        e.ch     = ch;
        cq.push_back(e);
    endtask

    task automatic write(input int c, input int r, input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_col  = 7'(c);
        wr_row  = 5'(r);
        wr_char = ch;
        cycle();
        wr_en = 1'b0;
        if (c < 80 && r < 30) model[r * 80 + c] = ch;
    endtask

    task automatic sweep(input int lo, input int hi,
                         input int sk_lo, input int sk_hi);
        for (int a = lo; a <= hi; a++) begin
            if (a >= sk_lo && a <= sk_hi) continue;
            push_pix((a % 80) * 8 + a % 8, (a / 80) * 16 + (a / 8) % 16,
                     1'b1, 1'b0);
            cycle();
        end
        idle(4);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        cyc = 0; n_tests = 0; n_fail = 0;
        for (int i = 0; i < 2400; i++) model[i] = 8'h20;

        // reset, with busy inputs that must be ignored
        reset = 1'b1; video_on = 1'b1; pixel_x = '0; pixel_y = '0;
        wr_en = 1'b1; wr_col = 7'd1; wr_row = '0; wr_char = 8'h77;
        clear_req = 1'b1;
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_char_code", 32'(char_code), 32'h00);
        chk("rst_rom_row", 32'(rom_row), 32'h0);
        chk("rst_text_pixel", 32'(text_pixel), 32'h0);
        chk("rst_text_valid", 32'(text_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0; wr_en = 1'b0; clear_req = 1'b0;
        idle(2);
        chk("busy_after_rst", 32'(busy), 32'h0);

        // 'A' at top-left, row 0 of glyph
        write(0, 0, 8'h41);
        for (int x = 0; x < 8; x++) begin
            push_pix(x, 0, 1'b1, 1'b0);
            cycle();
        end
        idle(4);

        // 'A' at bottom-right, row 6, then right edge + video off
        write(79, 29, 8'h41);
        for (int x = 632; x <= 640; x++) begin
            push_pix(x, 470, 1'b1, 1'b0);
            cycle();
        end
        push_pix(100, 100, 1'b0, 1'b0);
        cycle();
        push_pix(10, 480, 1'b1, 1'b0);
        cycle();
        idle(4);

        // random contents and random pixels
        for (int i = 0; i < 40; i++)
            write($urandom_range(0, 79), $urandom_range(0, 29),
                  8'($urandom));
        for (int i = 0; i < 200; i++) begin
            push_pix($urandom_range(0, 700), $urandom_range(0, 520),
                     1'($urandom_range(0, 3) != 0), 1'b0);
            cycle();
        end
        idle(4);

        // out-of-range writes must not alias into the buffer
        write(80, 0, 8'h41);
        write(127, 0, 8'h41);
        write(0, 31, 8'h41);
        sweep(0, 160, -1, -1);

        // clear with coincident write, ignored traffic while busy
        wr_en = 1'b1; wr_col = 7'd3; wr_row = 5'd3; wr_char = 8'h41;
        clear_req = 1'b1;
        cycle();
        wr_en = 1'b0; clear_req = 1'b0;
        chk("busy_start", 32'(busy), 32'h1);
        for (int i = 0; i < 2400; i++) model[i] = 8'h20;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            cnt++;
            wr_en     = (cnt == 500);
            wr_col    = 7'd5; wr_row = 5'd5; wr_char = 8'h55;
            clear_req = (cnt == 700);
            if (cnt >= 1000 && cnt < 1008)
                push_pix(cnt - 1000, 0, 1'b1, 1'b1);
            else
                video_on = 1'b0;
            cycle();
        end
        wr_en = 1'b0; clear_req = 1'b0;
        chk("busy_len", 32'(cnt), 32'd2400);
        sweep(0, 2399, -1, -1);

        // reset in the middle of a clear
        for (int a = 0; a < 200; a++) write(a % 80, a / 80, 8'h41);
        write(0, 25, 8'h41);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) cnt++;
            if (cnt == 100) break;
            cycle();
        end
        chk("busy_before_abort", 32'(cnt), 32'd100);
        reset = 1'b1; clear_req = 1'b1;
        wr_en = 1'b1; wr_col = 7'd0; wr_row = 5'd25; wr_char = 8'h99;
        cycle();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_char_code", 32'(char_code), 32'h00);
        chk("abort_text_valid", 32'(text_valid), 32'h0);
        reset = 1'b0; clear_req = 1'b0; wr_en = 1'b0;
        idle(3);
        chk("no_clear_after_abort", 32'(busy), 32'h0);
        for (int a = 0; a < 99; a++) model[a] = 8'h20;
        sweep(0, 199, 96, 101);
        sweep(2000, 2000, -1, -1);

        chk("queue_empty", 32'(pq.size() + cq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 Parameter COLS, 80, character columns per screen (8-pixel-wide cells).
REQ-002 Parameter ROWS, 30, character rows per screen (16-pixel-tall cells).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pixel_x  input  10  current pixel column from VGA timing.
REQ-006 pixel_y  input  10  current pixel row from VGA timing.
REQ-007 video_on  input  1  visible-area qualifier.
REQ-008 wr_en  input  1  text-buffer write strobe, one cell per cycle.
REQ-009 wr_col  input  7  target cell column.
REQ-010 wr_row  input  5  target cell row.
REQ-011 wr_char  input  8  character code to store.
REQ-012 clear_req  input  1  one-cycle pulse; fill whole buffer with 0x20.
REQ-013 char_code  output  8  character code driven to the character ROM.
REQ-014 rom_row  output  4  glyph row index driven to the character ROM.
REQ-015 row_data  input  8  combinational glyph row returned by the character ROM, bit 7 = leftmost pixel.
REQ-016 text_pixel  output  1  foreground pixel, aligned to pipeline latency.
REQ-017 text_valid  output  1  delayed video_on qualified by in-range coordinates.
REQ-018 busy  output  1  high while clear sequence runs.

Function
REQ-019 Text buffer SHALL hold COLS*ROWS 8-bit entries at address row*COLS+col, synchronous read, read-first on same-address read/write collision.
REQ-020 Buffer power-up contents SHALL be 0x20 in every cell; reset SHALL NOT alter buffer contents.
REQ-021 Writes with wr_col >= COLS or wr_row >= ROWS SHALL be ignored.
REQ-022 Pipeline stage 1 SHALL register buffer read address from pixel_x[9:3], pixel_y[8:4], plus pixel_x[2:0], pixel_y[3:0], video_on and in-range flag.
REQ-023 Stage 2 SHALL present buffer output on char_code and delayed pixel_y[3:0] on rom_row (both registered).
REQ-024 Stage 3 SHALL register text_pixel = row_data[7 - delayed pixel_x[2:0]] and text_valid.
REQ-025 Latency from pixel_x/pixel_y/video_on to text_pixel/text_valid SHALL be exactly 3 clk cycles, one new pixel accepted every cycle.
REQ-026 In-range SHALL mean pixel_x < COLS*8 and pixel_y < ROWS*16; out-of-range or video_on low SHALL yield text_pixel=0, text_valid=0.
REQ-027 FSM states IDLE and CLEAR; IDLE->CLEAR on clear_req, CLEAR->IDLE after writing final address COLS*ROWS-1.
REQ-028 In CLEAR, an internal counter starting at 0 SHALL write 0x20 to one address per cycle; busy=1 in CLEAR, duration exactly COLS*ROWS cycles.
REQ-029 In CLEAR, wr_en SHALL be ignored and text_pixel forced 0 (text_valid unaffected).
REQ-030 clear_req while busy SHALL be ignored; clear_req and wr_en in same IDLE cycle: clear starts, write dropped.
REQ-031 Counter wrap: after address COLS*ROWS-1, counter SHALL return to 0 and FSM to IDLE on the next edge.

Reset
REQ-032 Reset SHALL force FSM=IDLE, clear counter=0, busy=0, char_code=0x00, rom_row=0, text_pixel=0, text_valid=0, all pipeline registers zero.
REQ-033 Reset during CLEAR SHALL abort immediately; already-cleared cells stay 0x20, remaining cells keep prior contents.
REQ-034 Inputs sampled during reset SHALL have no effect on buffer or outputs.

Verification
REQ-035 Write 0x41 at col 0,row 0; drive pixel_y=0, pixel_x=0..7 on consecutive cycles with video_on=1 -> char_code=0x41, rom_row=0 two cycles later and text_pixel 0,0,1,1,1,1,0,0 three cycles after each input.
REQ-036 Write 0x41 at col 79,row 29; sweep pixel_x=632..639, pixel_y=470 -> rom_row=6, pixel pattern 0,1,1,0,0,1,1,0; pixel_x=640 -> text_pixel=0, text_valid=0.
REQ-037 Pulse clear_req -> busy=1 next cycle for exactly 2400 cycles; wr_en during busy ignored; afterwards every cell reads 0x20, text_pixel=0 across full frame.
REQ-038 Assert reset at cycle 100 of a clear -> busy=0 next cycle; cells 0..~99 read 0x20, cell 2000 retains prior 0x41.
REQ-039 Write wr_col=80,row 0 with 0x41 -> no cell changes; same-cycle wr_en and clear_req -> written cell reads 0x20 after clear.
